i2c_reg_target: RTL
===================

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 Parameter: I2C_ADDR, 7'h70, 7-bit target address matched against the first byte after START.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer flops on scl_in and sda_in (legal range 2-3).
REQ-003 Port: clk  input  1  system clock; all logic on its rising edge; ≥10x SCL frequency.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: scl_in  input  1  raw I2C clock from pad (asynchronous).
REQ-006 Port: sda_in  input  1  raw I2C data from pad (asynchronous).
REQ-007 Port: sda_oe  output  1  1 = pull SDA low (open-drain); pad output value is tied 0 externally.
REQ-008 Port: wr_en  output  1  one-clk strobe; register write valid.
REQ-009 Port: wr_addr  output  8  register address for current write.
REQ-010 Port: wr_data  output  8  register data for current write.
REQ-011 Port: busy  output  1  high from a detected START until the next detected STOP.

Function
REQ-012 scl_in/sda_in SHALL each pass through SYNC_STAGES flops, plus one history flop for edge detection; all decisions use synchronized values only.
REQ-013 START/repeated START = synchronized SDA falling while SCL high; STOP = SDA rising while SCL high; SCL edges are detected one clk after the synchronized change.
REQ-014 States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 Data bits SHALL be shifted MSB-first on each detected SCL rising edge; a bit counter 0..7 marks byte completion after the 8th rising edge.
REQ-016 START from any state -> ADDR, bit counter cleared, busy=1; STOP from any state -> IDLE, sda_oe=0, busy=0.
REQ-017 ADDR complete: byte[7:1]==I2C_ADDR and byte[0]==0 -> ADDR_ACK; any other value (including the read bit) -> IGNORE, no ACK driven.
REQ-018 On the SCL falling edge that ends the 8th bit of an acknowledged byte, sda_oe SHALL go 1; it SHALL go 0 on the next SCL falling edge (end of ACK clock).
REQ-019 After ADDR_ACK -> SUB; SUB byte loads internal pointer; SUB_ACK -> DATA.
REQ-020 DATA byte complete: wr_addr=pointer, wr_data=byte, wr_en=1 for exactly one clk on the cycle of the 8th SCL rising edge; pointer increments by 1 in the same cycle, modulo 256 (8'hFF -> 8'h00); then DATA_ACK -> DATA.
REQ-021 IGNORE: sda_oe held 0, no writes; leaves only on START or STOP.
REQ-022 A START or STOP arriving mid-byte SHALL discard the partial byte with no wr_en pulse; the pointer is retained.
REQ-023 wr_addr/wr_data SHALL hold their values between strobes.
REQ-024 sda_oe SHALL never be 1 outside ADDR_ACK, SUB_ACK or DATA_ACK.

Reset
REQ-025 rst=1 at a clk edge: state=IDLE, sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0, shift register and counter cleared, synchronizers set to 1 (bus idle).
REQ-026 Reset asserted mid-transaction SHALL abort it immediately; after release the block ignores the bus until the next START.

Verification
REQ-027 START, 0xE0, 0x0A, 0x55, 0x1F, STOP -> ACK on 4 bytes; writes (0x0A,0x55) then (0x0B,0x1F); busy falls at STOP.
REQ-028 START, 0xE2 (address 0x71) and 0x7E, 0xAA -> sda_oe stays 0 throughout; no wr_en.
REQ-029 START, 0xE1 (read bit) -> NACK; state IGNORE until STOP; no wr_en.
REQ-030 START, 0xE0, 0xFF, 0x11, 0x22, STOP -> writes (0xFF,0x11), (0x00,0x22): pointer wrap.
REQ-031 START, 0xE0, 0x05, 4 data bits, repeated START, 0xE0, 0x20, 0x33, STOP -> no write for the partial byte; single write (0x20,0x33).
REQ-032 rst pulsed during the 5th data bit -> sda_oe=0 and no wr_en; the next full transaction writes correctly.

Source files
------------

// File: rtl/i2c_reg_target.sv
// ---------------------------------------------------------------------------
// i2c_reg_target
//
// Write-only I2C target that turns bus transactions of the form
//   START, {I2C_ADDR, W}, sub-address, data0, data1, ..., STOP
// into register write strobes. The sub-address loads an internal pointer,
// and each data byte is written to the pointer, which then increments
// modulo 256. Reads, other addresses and partial bytes produce no writes.
//
// Parameters
//   I2C_ADDR     7-bit target address matched in the first byte after START
//   SYNC_STAGES  synchronizer depth on scl_in / sda_in (2 or 3)
//
// Ports
//   clk      in   system clock, at least 10x the SCL frequency
//   rst      in   synchronous active-high reset
//   scl_in   in   raw SCL from the pad (asynchronous)
//   sda_in   in   raw SDA from the pad (asynchronous)
//   sda_oe   out  1 = pull SDA low (ACK); the pad output value is tied 0
//   wr_en    out  one-clk write strobe
//   wr_addr  out  register address of the current write (held)
//   wr_data  out  register data of the current write (held)
//   busy     out  high from a detected START until the next detected STOP
// ---------------------------------------------------------------------------
module i2c_reg_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h70,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  // Protocol states
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_SUB      = 3'd3;
  localparam logic [2:0] S_SUB_ACK  = 3'd4;
  localparam logic [2:0] S_DATA     = 3'd5;
  localparam logic [2:0] S_DATA_ACK = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  // Synchronizers plus one history flop each for edge detection
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  logic [2:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_sda_oe;
  logic       r_wr_en;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_busy;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_byte_done;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise =  w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl &  r_scl_d;

  // SDA may only move while SCL is low during data; a transition with SCL
  // held high across both samples is a bus condition.
  assign w_start = r_sda_d & ~w_sda & w_scl & r_scl_d;
  assign w_stop  = ~r_sda_d & w_sda & w_scl & r_scl_d;

  // Byte as it will look once the bit sampled on this rising edge lands
  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 3'd7);

  assign sda_oe  = r_sda_oe;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizers reset to 1 so a released reset looks like an idle bus
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_ptr      <= 8'h00;
      r_sda_oe   <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;

      // NOTE: the strobe defaults low every cycle so it can only ever be a
      // single-clk pulse, whatever branch below raises it.
      r_wr_en <= 1'b0;

      if (w_start) begin
        // START or repeated START: any partial byte is dropped, pointer kept
        r_state   <= S_ADDR;
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_SUB, S_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte;
              // 3-bit counter wraps 7 -> 0, ready for the byte after the ACK
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              case (r_state)
                S_ADDR: begin
                  if (w_byte[7:1] == I2C_ADDR && !w_byte[0]) begin
                    r_state <= S_ADDR_ACK;
                  end else begin
                    r_state <= S_IGNORE;
                  end
                end
                S_SUB: begin
                  r_ptr   <= w_byte;
                  r_state <= S_SUB_ACK;
                end
                default: begin
                  r_wr_en   <= 1'b1;
                  r_wr_addr <= r_ptr;
                  r_wr_data <= w_byte;
                  r_ptr     <= r_ptr + 8'd1;
                  r_state   <= S_DATA_ACK;
                end
              endcase
            end
          end

          S_ADDR_ACK, S_SUB_ACK, S_DATA_ACK: begin
            // First falling edge ends bit 8: start pulling SDA low.
            // Second falling edge ends the ACK clock: release and move on.
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= (r_state == S_ADDR_ACK) ? S_SUB : S_DATA;
              end
            end
          end

          default: begin
            // IDLE and IGNORE wait for a bus condition; SDA stays released
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
